bidir_buff: RTL and testbench

- Clocked, direction-controlled bidirectional tri-state buffer between two inout buses, `a` and `b`.
- `control=1`: the `a` side is the source and the block drives `b` with the value of `a`.
- `control=0`: the `b` side is the source and the block drives `a` with the value of `b`.
- A registered direction controller inserts a programmable high-Z turnaround on every direction change, so both sides are never driven at once. Sits at chip or board-level shared-bus boundaries.

---
 rtl/bidir_buff_pkg.sv | 18 +
 rtl/bidir_buff_tristate_drv.sv | 12 +
 rtl/bidir_buff.sv | 87 ++++++++
 tb/tb_bidir_buff.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/bidir_buff_pkg.sv
// bidir_buff_pkg: shared state encoding, direction constants and counter sizing
package bidir_buff_pkg;

    typedef enum logic [1:0] {
        TURN    = 2'd0,
        DRIVE_A = 2'd1,
        DRIVE_B = 2'd2
    } state_t;

    localparam logic DIR_A_TO_B = 1'b1;
    localparam logic DIR_B_TO_A = 1'b0;

    // Turnaround counter must hold TURNAROUND itself; never narrower than one bit.
    function automatic int cnt_width(input int turnaround);
        return (turnaround < 1) ? 1 : $clog2(turnaround + 1);
    endfunction

endpackage

// File: rtl/bidir_buff_tristate_drv.sv
// tristate_drv: WIDTH-bit tri-state driver, passes src onto dst when enabled
module tristate_drv #(
    parameter int WIDTH = 1
) (
    input  logic             en,
    input  logic [WIDTH-1:0] src,
    output wire  [WIDTH-1:0] dst
);

    assign dst = en ? src : {WIDTH{1'bz}};

endmodule

// File: rtl/bidir_buff.sv
// bidir_buff: direction-controlled bidirectional buffer with high-Z turnaround
module bidir_buff
    import bidir_buff_pkg::*;
#(
    parameter int WIDTH      = 1,
    parameter int TURNAROUND = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             control,
    inout  wire  [WIDTH-1:0] a,
    inout  wire  [WIDTH-1:0] b,
    output logic             dir_o,
    output logic             busy_o
);

    localparam int CW = cnt_width(TURNAROUND);
    // Full load used at reset; a detected change leaves TURNAROUND-1 because
    // the detecting edge already opens the first released cycle.
    localparam logic [CW-1:0] CNT_FULL = CW'(TURNAROUND);
    localparam logic [CW-1:0] CNT_SWAP = CW'((TURNAROUND == 0) ? 0 : TURNAROUND - 1);

    state_t          state, state_n;
    logic [CW-1:0]   cnt, cnt_n;
    logic            dir_q, dir_n;
    logic            en_a, en_b;
    logic            change;

    assign change = (control != dir_q);
    assign dir_o  = dir_q;
    assign busy_o = (state == TURN);

    // Next-state, counter and committed-direction logic.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        dir_n   = dir_q;
        if (state == TURN) begin
            if (change) begin
                dir_n = control;
                cnt_n = CNT_SWAP;
            end else if (cnt == '0) begin
                state_n = (dir_q == DIR_A_TO_B) ? DRIVE_B : DRIVE_A;
            end else begin
                cnt_n = cnt - 1'b1;
            end
        end else if (change) begin
            dir_n = control;
            if (TURNAROUND == 0) begin
                state_n = (control == DIR_A_TO_B) ? DRIVE_B : DRIVE_A;
            end else begin
                state_n = TURN;
                cnt_n   = CNT_SWAP;
            end
        end
    end

    // State register with registered, mutually exclusive drive enables.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= TURN;
            cnt   <= CNT_FULL;
            dir_q <= control;
            en_a  <= 1'b0;
            en_b  <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            dir_q <= dir_n;
            en_a  <= (state_n == DRIVE_A);
            en_b  <= (state_n == DRIVE_B);
        end
    end

    tristate_drv #(.WIDTH(WIDTH)) u_a_to_b (
        .en  (en_b),
        .src (a),
        .dst (b)
    );

    tristate_drv #(.WIDTH(WIDTH)) u_b_to_a (
        .en  (en_a),
        .src (b),
        .dst (a)
    );

endmodule

// File: tb/tb_bidir_buff.sv
// tb_bidir_buff: directed checks of bidir_buff across turnaround settings
module tb_bidir_buff;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // TURNAROUND=1, WIDTH=1
    logic rst1 = 1'b0, c1 = 1'b1, a1_oe = 1'b0, a1_d = 1'b0, b1_oe = 1'b0, b1_d = 1'b0;
    wire  a1, b1, dir1, busy1;
    assign a1 = a1_oe ? a1_d : 1'bz;
    assign b1 = b1_oe ? b1_d : 1'bz;
    bidir_buff #(.WIDTH(1), .TURNAROUND(1)) d1 (
        .clk(clk), .rst_n(rst1), .control(c1), .a(a1), .b(b1), .dir_o(dir1), .busy_o(busy1));

    // TURNAROUND=3, WIDTH=1
    logic rst3 = 1'b0, c3 = 1'b1;
    wire  a3, b3, dir3, busy3;
    bidir_buff #(.WIDTH(1), .TURNAROUND(3)) d3 (
        .clk(clk), .rst_n(rst3), .control(c3), .a(a3), .b(b3), .dir_o(dir3), .busy_o(busy3));

    // TURNAROUND=0, WIDTH=1
    logic rst0 = 1'b0, c0 = 1'b1;
    wire  a0, b0, dir0, busy0;
    bidir_buff #(.WIDTH(1), .TURNAROUND(0)) d0 (
        .clk(clk), .rst_n(rst0), .control(c0), .a(a0), .b(b0), .dir_o(dir0), .busy_o(busy0));

    // TURNAROUND=1, WIDTH=8
    logic       rst8 = 1'b0, c8 = 1'b0, a8_oe = 1'b0, b8_oe = 1'b0;
    logic [7:0] a8_d = 8'h00, b8_d = 8'h00;
    wire  [7:0] a8, b8;
    wire        dir8, busy8;
    assign a8 = a8_oe ? a8_d : 8'bz;
    assign b8 = b8_oe ? b8_d : 8'bz;
    bidir_buff #(.WIDTH(8), .TURNAROUND(1)) d8 (
        .clk(clk), .rst_n(rst8), .control(c8), .a(a8), .b(b8), .dir_o(dir8), .busy_o(busy8));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        a1_oe = 1'b1; a1_d = 1'b1; c1 = 1'b1; rst1 = 1'b0;
        tick(); tick();
        total++; if (busy1 !== 1'b1) begin bad++; $display("FAIL rst_busy: got %b want 1", busy1); end
        total++; if (dir1 !== 1'b1) begin bad++; $display("FAIL rst_dir: got %b want 1", dir1); end
        total++; if ({d1.en_a, d1.en_b} !== 2'b00) begin bad++; $display("FAIL rst_en: got %b want 00", {d1.en_a, d1.en_b}); end
        rst1 = 1'b1;
        tick();
        total++; if (busy1 !== 1'b1) begin bad++; $display("FAIL rel_busy: got %b want 1", busy1); end
        total++; if ({d1.en_a, d1.en_b} !== 2'b00) begin bad++; $display("FAIL rel_en: got %b want 00", {d1.en_a, d1.en_b}); end
        tick();
        total++; if (busy1 !== 1'b0) begin bad++; $display("FAIL drvb_busy: got %b want 0", busy1); end
        total++; if ({d1.en_a, d1.en_b} !== 2'b01) begin bad++; $display("FAIL drvb_en: got %b want 01", {d1.en_a, d1.en_b}); end
        total++; if (b1 !== 1'b1) begin bad++; $display("FAIL drvb_data: got %b want 1", b1); end
    endtask

    task automatic test_stable();
        for (int i = 0; i < 4; i++) begin
            a1_d = i[0];
            #1;
            total++; if (b1 !== a1_d) begin bad++; $display("FAIL track_b[%0d]: got %b want %b", i, b1, a1_d); end
            #4;
        end
        total++; if (dir1 !== 1'b1) begin bad++; $display("FAIL stable_dir: got %b want 1", dir1); end
        tick();
    endtask

    task automatic test_switch();
        c1 = 1'b0;
        tick();
        total++; if (busy1 !== 1'b1) begin bad++; $display("FAIL sw_busy: got %b want 1", busy1); end
        total++; if (dir1 !== 1'b0) begin bad++; $display("FAIL sw_dir: got %b want 0", dir1); end
        total++; if ({d1.en_a, d1.en_b} !== 2'b00) begin bad++; $display("FAIL sw_en: got %b want 00", {d1.en_a, d1.en_b}); end
        a1_oe = 1'b0; b1_oe = 1'b1; b1_d = 1'b0;
        tick();
        total++; if (busy1 !== 1'b0) begin bad++; $display("FAIL sw_done_busy: got %b want 0", busy1); end
        total++; if ({d1.en_a, d1.en_b} !== 2'b10) begin bad++; $display("FAIL sw_done_en: got %b want 10", {d1.en_a, d1.en_b}); end
        total++; if (a1 !== 1'b0) begin bad++; $display("FAIL track_a0: got %b want 0", a1); end
        b1_d = 1'b1;
        #1;
        total++; if (a1 !== 1'b1) begin bad++; $display("FAIL track_a1: got %b want 1", a1); end
        tick();
    endtask

    task automatic test_periodic();
        for (int s = 0; s < 4; s++) begin
            c1 = ~c1;
            tick();
            total++; if (busy1 !== 1'b1) begin bad++; $display("FAIL per_busy[%0d]: got %b want 1", s, busy1); end
            total++; if (dir1 !== c1) begin bad++; $display("FAIL per_dir[%0d]: got %b want %b", s, dir1, c1); end
            a1_oe = c1; b1_oe = ~c1;
            tick();
            total++; if (busy1 !== 1'b0) begin bad++; $display("FAIL per_idle[%0d]: got %b want 0", s, busy1); end
            total++; if ({d1.en_a, d1.en_b} !== {~c1, c1}) begin bad++; $display("FAIL per_en[%0d]: got %b want %b", s, {d1.en_a, d1.en_b}, {~c1, c1}); end
            a1_d = ~s[0]; b1_d = s[0];
            #1;
            total++; if ((c1 ? b1 : a1) !== (c1 ? a1_d : b1_d)) begin bad++; $display("FAIL per_data[%0d]: got %b want %b", s, c1 ? b1 : a1, c1 ? a1_d : b1_d); end
            for (int k = 0; k < 3; k++) begin
                tick();
                total++; if (d1.en_a & d1.en_b) begin bad++; $display("FAIL per_overlap[%0d]: got 11 want not 11", s); end
            end
        end
    endtask

    task automatic test_restart();
        c3 = 1'b1; rst3 = 1'b1;
        repeat (5) tick();
        total++; if ({busy3, d3.en_b} !== 2'b01) begin bad++; $display("FAIL rs_pre: got %b want 01", {busy3, d3.en_b}); end
        c3 = 1'b0;
        tick();
        total++; if ({busy3, dir3} !== 2'b10) begin bad++; $display("FAIL rs_first: got %b want 10", {busy3, dir3}); end
        c3 = 1'b1;
        tick();
        total++; if ({busy3, dir3} !== 2'b11) begin bad++; $display("FAIL rs_second: got %b want 11", {busy3, dir3}); end
        for (int k = 0; k < 2; k++) begin
            tick();
            total++; if ({busy3, d3.en_a, d3.en_b} !== 3'b100) begin bad++; $display("FAIL rs_hold[%0d]: got %b want 100", k, {busy3, d3.en_a, d3.en_b}); end
        end
        tick();
        total++; if ({busy3, d3.en_a, d3.en_b} !== 3'b001) begin bad++; $display("FAIL rs_exit: got %b want 001", {busy3, d3.en_a, d3.en_b}); end
    endtask

    task automatic test_turn0();
        total++; if (busy0 !== 1'b1) begin bad++; $display("FAIL t0_rst_busy: got %b want 1", busy0); end
        c0 = 1'b1; rst0 = 1'b1;
        tick();
        total++; if ({busy0, d0.en_a, d0.en_b} !== 3'b001) begin bad++; $display("FAIL t0_start: got %b want 001", {busy0, d0.en_a, d0.en_b}); end
        c0 = 1'b0;
        tick();
        total++; if ({busy0, dir0, d0.en_a, d0.en_b} !== 4'b0010) begin bad++; $display("FAIL t0_to_a: got %b want 0010", {busy0, dir0, d0.en_a, d0.en_b}); end
        c0 = 1'b1;
        tick();
        total++; if ({busy0, dir0, d0.en_a, d0.en_b} !== 4'b0101) begin bad++; $display("FAIL t0_to_b: got %b want 0101", {busy0, dir0, d0.en_a, d0.en_b}); end
    endtask

    task automatic test_mid_reset();
        c8 = 1'b0; rst8 = 1'b1;
        tick(); tick();
        b8_oe = 1'b1; b8_d = 8'hA5;
        #1;
        total++; if (a8 !== 8'hA5) begin bad++; $display("FAIL mr_data0: got %h want a5", a8); end
        total++; if (d8.en_a !== 1'b1) begin bad++; $display("FAIL mr_en_a: got %b want 1", d8.en_a); end
        b8_d = 8'h3C;
        #1;
        total++; if (a8 !== 8'h3C) begin bad++; $display("FAIL mr_data1: got %h want 3c", a8); end
        rst8 = 1'b0; c8 = 1'b1;
        tick();
        total++; if ({busy8, dir8, d8.en_a, d8.en_b} !== 4'b1100) begin bad++; $display("FAIL mr_rst: got %b want 1100", {busy8, dir8, d8.en_a, d8.en_b}); end
        b8_oe = 1'b0; a8_oe = 1'b1; a8_d = 8'h5A; rst8 = 1'b1;
        tick();
        total++; if (busy8 !== 1'b1) begin bad++; $display("FAIL mr_turn: got %b want 1", busy8); end
        tick();
        total++; if ({busy8, d8.en_a, d8.en_b} !== 3'b001) begin bad++; $display("FAIL mr_en_b: got %b want 001", {busy8, d8.en_a, d8.en_b}); end
        total++; if (b8 !== 8'h5A) begin bad++; $display("FAIL mr_data2: got %h want 5a", b8); end
    endtask

    initial begin
        test_reset();
        test_stable();
        test_switch();
        test_periodic();
        test_restart();
        test_turn0();
        test_mid_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
